// File: rtl/dmem_guard_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_guard_pkg
// Description : Shared types and constants for the data-memory access guard.
//               Holds the region descriptor, the violation log entry layout,
//               the permission bit indices of cfg_perm_i and a window-match
//               helper used by every region slot.
// Ports       : none (package)
// Revision    : 1.0  initial release
// ============================================================================
package dmem_guard_pkg;

    localparam int c_ADDR_W = 32;
    localparam int c_DATA_W = 32;
    localparam int c_STRB_W = 4;
    localparam int c_TAG_W  = 11;

    // Bit positions inside the 3-bit {enable, write, read} permission field
    localparam int PERM_R  = 0;
    localparam int PERM_W  = 1;
    localparam int PERM_EN = 2;

    typedef struct packed {
        logic [c_ADDR_W-1:0] base;
        logic [c_ADDR_W-1:0] limit;
        logic                en;
        logic                w;
        logic                r;
    } region_t;

    typedef struct packed {
        logic [c_ADDR_W-1:0] addr;
        logic [c_DATA_W-1:0] data;
        logic [c_STRB_W-1:0] strb;
        logic [c_TAG_W-1:0]  tag;
    } log_entry_t;

    // Inclusive, unsigned window match; a disabled region never matches.
    function automatic logic region_hit(input region_t rgn, input logic [c_ADDR_W-1:0] addr);
        return rgn.en && (addr >= rgn.base) && (addr <= rgn.limit);
    endfunction

endpackage : dmem_guard_pkg
`default_nettype wire

// File: rtl/dmem_guard_log_fifo.sv
`default_nettype none
// ============================================================================
// Module      : dmem_guard_log_fifo
// Description : Synchronous FIFO of violation log entries. Pointers carry one
//               extra wrap bit so full and empty are told apart without a
//               counter. A push into a full FIFO succeeds only when a pop
//               happens in the same cycle; otherwise it is reported on drop_o.
//               The head is taken purely from flops and forced to zero while
//               empty.
// Ports       : clk_i, rst_ni      clock, async active-low reset
//               push_i, data_i     write request and entry
//               pop_i              remove head (ignored when empty)
//               head_o             current head entry (0 when empty)
//               full_o, empty_o    occupancy flags
//               drop_o             push rejected this cycle
// Revision    : 1.0  initial release
// ============================================================================
module dmem_guard_log_fifo
    import dmem_guard_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       push_i,
    input  log_entry_t data_i,
    input  logic       pop_i,
    output log_entry_t head_o,
    output logic       full_o,
    output logic       empty_o,
    output logic       drop_o
);

    localparam int c_PTR_W = $clog2(DEPTH);

    logic [c_PTR_W:0] r_wr_ptr;
    logic [c_PTR_W:0] r_rd_ptr;
    log_entry_t       r_mem [DEPTH];

    logic w_empty;
    logic w_full;
    logic w_do_push;
    logic w_do_pop;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[c_PTR_W] != r_rd_ptr[c_PTR_W]) &&
                     (r_wr_ptr[c_PTR_W-1:0] == r_rd_ptr[c_PTR_W-1:0]);

    // A pop frees the head slot in the same cycle, so a push into a full
    // FIFO is still taken when it coincides with a pop.
    assign w_do_pop  = pop_i & ~w_empty;
    assign w_do_push = push_i & (~w_full | w_do_pop);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + {{c_PTR_W{1'b0}}, 1'b1};
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + {{c_PTR_W{1'b0}}, 1'b1};
            end
        end
    end

    // Storage needs no reset: contents are only visible through the
    // empty-gated head.
    always_ff @(posedge clk_i) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[c_PTR_W-1:0]] <= data_i;
        end
    end

    assign head_o  = w_empty ? '0 : r_mem[r_rd_ptr[c_PTR_W-1:0]];
    assign full_o  = w_full;
    assign empty_o = w_empty;
    assign drop_o  = push_i & ~w_do_push;

endmodule : dmem_guard_log_fifo
`default_nettype wire

// File: rtl/dmem_access_guard.sv
`default_nettype none
// ============================================================================
// Module      : dmem_access_guard
// Description : Access guard between the core data port and the memory
//               fabric. Each load/store is checked against NUM_REGIONS
//               programmable windows (lowest index wins). Denied accesses are
//               either blocked and answered with an error response, or passed
//               through when enforce_i is low. Every violation is logged into
//               a FIFO and counted with a saturating counter.
// Ports       : clk_i, rst_ni                     clock, async active-low reset
//               core_*_i / core_*_o               core request / response side
//               mem_*_o / mem_*_i                 fabric request / response side
//               enforce_i                         1 = block denied accesses
//               cfg_we_i, cfg_idx_i, cfg_base_i,
//               cfg_limit_i, cfg_perm_i           region programming
//               log_valid_o, log_pop_i, log_*_o   violation log head and pop
//               log_overflow_o                    sticky entry-dropped flag
//               viol_count_o                      saturating violation count
//               stat_clr_i                        clear count and overflow
// Revision    : 1.0  initial release
// ============================================================================
module dmem_access_guard
    import dmem_guard_pkg::*;
#(
    parameter int NUM_REGIONS   = 4,
    parameter int LOG_DEPTH     = 8,
    parameter int CNT_W         = 16,
    parameter bit DEFAULT_ALLOW = 1'b0,
    parameter int IDX_W         = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    // core side
    input  logic [31:0]         core_addr_i,
    input  logic [31:0]         core_data_wr_i,
    input  logic                core_rd_i,
    input  logic [3:0]          core_wr_i,
    input  logic                core_cacheable_i,
    input  logic [10:0]         core_req_tag_i,
    output logic                core_accept_o,
    output logic [31:0]         core_data_rd_o,
    output logic                core_ack_o,
    output logic                core_error_o,
    output logic [10:0]         core_resp_tag_o,
    // memory side
    output logic [31:0]         mem_addr_o,
    output logic [31:0]         mem_data_wr_o,
    output logic                mem_rd_o,
    output logic [3:0]          mem_wr_o,
    output logic                mem_cacheable_o,
    output logic [10:0]         mem_req_tag_o,
    input  logic                mem_accept_i,
    input  logic [31:0]         mem_data_rd_i,
    input  logic                mem_ack_i,
    input  logic                mem_error_i,
    input  logic [10:0]         mem_resp_tag_i,
    // control and configuration
    input  logic                enforce_i,
    input  logic                cfg_we_i,
    input  logic [IDX_W-1:0]    cfg_idx_i,
    input  logic [31:0]         cfg_base_i,
    input  logic [31:0]         cfg_limit_i,
    input  logic [2:0]          cfg_perm_i,
    // violation log and statistics
    output logic                log_valid_o,
    input  logic                log_pop_i,
    output logic [31:0]         log_addr_o,
    output logic [31:0]         log_data_o,
    output logic [3:0]          log_strb_o,
    output logic [10:0]         log_tag_o,
    output logic                log_overflow_o,
    output logic [CNT_W-1:0]    viol_count_o,
    input  logic                stat_clr_i
);

    // ------------------------------------------------------------------------
    // Error-response state machine
    // ------------------------------------------------------------------------
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_ERR  = 1'b1;

    logic [0:0] r_state;
    logic [0:0] w_state_nxt;
    logic [10:0] r_err_tag;

    // ------------------------------------------------------------------------
    // Request classification and region decode
    // ------------------------------------------------------------------------
    logic                   w_is_store;
    logic                   w_req;
    logic [NUM_REGIONS-1:0] w_match;
    logic [NUM_REGIONS-1:0] w_rd_ok;
    logic [NUM_REGIONS-1:0] w_wr_ok;
    logic                   w_sel_r;
    logic                   w_sel_w;
    logic                   w_allowed;
    logic                   w_denied;
    logic                   w_block;
    logic                   w_err_pend;
    logic                   w_fwd;
    logic                   w_viol;

    assign w_is_store = |core_wr_i;
    assign w_req      = core_rd_i | w_is_store;

    for (genvar g = 0; g < NUM_REGIONS; g++) begin : g_region
        region_t r_region;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_region <= '0;
            end else if (cfg_we_i && (cfg_idx_i == IDX_W'(g))) begin
                r_region.base  <= cfg_base_i;
                r_region.limit <= cfg_limit_i;
                r_region.en    <= cfg_perm_i[PERM_EN];
                r_region.w     <= cfg_perm_i[PERM_W];
                r_region.r     <= cfg_perm_i[PERM_R];
            end
        end

        assign w_match[g] = region_hit(r_region, core_addr_i);
        assign w_rd_ok[g] = r_region.r;
        assign w_wr_ok[g] = r_region.w;
    end

    // Walk from the highest index down so the lowest matching region is the
    // last one written and therefore decides.
    always_comb begin
        w_sel_r = 1'b0;
        w_sel_w = 1'b0;
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            if (w_match[i]) begin
                w_sel_r = w_rd_ok[i];
                w_sel_w = w_wr_ok[i];
            end
        end
    end

    assign w_allowed  = (|w_match) ? (w_is_store ? w_sel_w : w_sel_r) : DEFAULT_ALLOW;
    assign w_denied   = w_req & ~w_allowed;
    assign w_block    = w_denied & enforce_i;
    assign w_err_pend = (r_state == S_ERR);

    // A blocked request is taken by the guard itself, so it does not wait
    // for the fabric to accept.
    assign core_accept_o = ~w_err_pend & (w_block | mem_accept_i);
    assign w_fwd         = w_req & ~w_block & ~w_err_pend;
    assign w_viol        = w_denied & core_accept_o;

    assign mem_addr_o      = w_fwd ? core_addr_i      : '0;
    assign mem_data_wr_o   = w_fwd ? core_data_wr_i   : '0;
    assign mem_rd_o        = w_fwd & core_rd_i;
    assign mem_wr_o        = w_fwd ? core_wr_i        : '0;
    assign mem_cacheable_o = w_fwd & core_cacheable_i;
    assign mem_req_tag_o   = w_fwd ? core_req_tag_i   : '0;

    // ------------------------------------------------------------------------
    // FSM: state register / next state / outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_block) begin
                    w_state_nxt = S_ERR;
                end
            end
            S_ERR: begin
                // A fabric response owns the response port this cycle; the
                // error is retried on the next free cycle.
                if (!mem_ack_i) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        core_ack_o      = 1'b0;
        core_error_o    = 1'b0;
        core_data_rd_o  = '0;
        core_resp_tag_o = '0;
        if (mem_ack_i) begin
            core_ack_o      = 1'b1;
            core_error_o    = mem_error_i;
            core_data_rd_o  = mem_data_rd_i;
            core_resp_tag_o = mem_resp_tag_i;
        end else if (w_err_pend) begin
            core_ack_o      = 1'b1;
            core_error_o    = 1'b1;
            core_resp_tag_o = r_err_tag;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_err_tag <= '0;
        end else if ((r_state == S_IDLE) && w_block) begin
            r_err_tag <= core_req_tag_i;
        end
    end

    // ------------------------------------------------------------------------
    // Violation log and statistics
    // ------------------------------------------------------------------------
    log_entry_t w_push_entry;
    log_entry_t w_head;
    logic       w_fifo_full;
    logic       w_fifo_empty;
    logic       w_drop;

    assign w_push_entry.addr = core_addr_i;
    assign w_push_entry.data = w_is_store ? core_data_wr_i : '0;
    assign w_push_entry.strb = core_wr_i;
    assign w_push_entry.tag  = core_req_tag_i;

    dmem_guard_log_fifo #(
        .DEPTH   (LOG_DEPTH)
    ) u_log_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (w_viol),
        .data_i  (w_push_entry),
        .pop_i   (log_pop_i),
        .head_o  (w_head),
        .full_o  (w_fifo_full),
        .empty_o (w_fifo_empty),
        .drop_o  (w_drop)
    );

    assign log_valid_o = ~w_fifo_empty;
    assign log_addr_o  = w_head.addr;
    assign log_data_o  = w_head.data;
    assign log_strb_o  = w_head.strb;
    assign log_tag_o   = w_head.tag;

    logic [CNT_W-1:0] r_viol_cnt;
    logic             r_overflow;

    // A clear that coincides with a violation keeps that violation: the count
    // restarts at one and the flag reflects this cycle's push.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_viol_cnt <= '0;
            r_overflow <= 1'b0;
        end else if (stat_clr_i) begin
            r_viol_cnt <= w_viol ? CNT_W'(1) : '0;
            r_overflow <= w_drop;
        end else begin
            if (w_viol && !(&r_viol_cnt)) begin
                r_viol_cnt <= r_viol_cnt + CNT_W'(1);
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign viol_count_o   = r_viol_cnt;
    assign log_overflow_o = r_overflow;

endmodule : dmem_access_guard
`default_nettype wire

// File: tb/tb_dmem_access_guard.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_access_guard
// Description : Self-checking bench for dmem_access_guard. A table of directed
//               request vectors with hand-computed results covers the region
//               decisions; short hand-written sequences cover the error/ack
//               collision, FIFO overflow, clear, config timing and reset.
// Revision    : 1.0  initial release
// ============================================================================
module tb_dmem_access_guard;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [31:0] core_addr_i, core_data_wr_i;
    logic        core_rd_i;
    logic [3:0]  core_wr_i;
    logic        core_cacheable_i;
    logic [10:0] core_req_tag_i;
    logic        core_accept_o;
    logic [31:0] core_data_rd_o;
    logic        core_ack_o, core_error_o;
    logic [10:0] core_resp_tag_o;
    logic [31:0] mem_addr_o, mem_data_wr_o;
    logic        mem_rd_o;
    logic [3:0]  mem_wr_o;
    logic        mem_cacheable_o;
    logic [10:0] mem_req_tag_o;
    logic        mem_accept_i;
    logic [31:0] mem_data_rd_i;
    logic        mem_ack_i, mem_error_i;
    logic [10:0] mem_resp_tag_i;
    logic        enforce_i, cfg_we_i;
    logic [1:0]  cfg_idx_i;
    logic [31:0] cfg_base_i, cfg_limit_i;
    logic [2:0]  cfg_perm_i;
    logic        log_valid_o, log_pop_i;
    logic [31:0] log_addr_o, log_data_o;
    logic [3:0]  log_strb_o;
    logic [10:0] log_tag_o;
    logic        log_overflow_o;
    logic [15:0] viol_count_o;
    logic        stat_clr_i;

    always #5 clk_i = ~clk_i;

    dmem_access_guard dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .core_addr_i(core_addr_i), .core_data_wr_i(core_data_wr_i),
        .core_rd_i(core_rd_i), .core_wr_i(core_wr_i),
        .core_cacheable_i(core_cacheable_i), .core_req_tag_i(core_req_tag_i),
        .core_accept_o(core_accept_o), .core_data_rd_o(core_data_rd_o),
        .core_ack_o(core_ack_o), .core_error_o(core_error_o),
        .core_resp_tag_o(core_resp_tag_o),
        .mem_addr_o(mem_addr_o), .mem_data_wr_o(mem_data_wr_o),
        .mem_rd_o(mem_rd_o), .mem_wr_o(mem_wr_o),
        .mem_cacheable_o(mem_cacheable_o), .mem_req_tag_o(mem_req_tag_o),
        .mem_accept_i(mem_accept_i), .mem_data_rd_i(mem_data_rd_i),
        .mem_ack_i(mem_ack_i), .mem_error_i(mem_error_i),
        .mem_resp_tag_i(mem_resp_tag_i),
        .enforce_i(enforce_i), .cfg_we_i(cfg_we_i), .cfg_idx_i(cfg_idx_i),
        .cfg_base_i(cfg_base_i), .cfg_limit_i(cfg_limit_i), .cfg_perm_i(cfg_perm_i),
        .log_valid_o(log_valid_o), .log_pop_i(log_pop_i),
        .log_addr_o(log_addr_o), .log_data_o(log_data_o),
        .log_strb_o(log_strb_o), .log_tag_o(log_tag_o),
        .log_overflow_o(log_overflow_o), .viol_count_o(viol_count_o),
        .stat_clr_i(stat_clr_i)
    );

    typedef struct packed {
        logic        rd;
        logic [3:0]  wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [10:0] tag;
        logic        enf;
        logic        macc;
        logic        exp_acc;
        logic        exp_fwd;
        logic        exp_viol;
        logic        exp_blk;
    } vec_t;

    localparam int c_NVEC   = 15;
    localparam int c_PHASE2 = 12;

    vec_t vecs [c_NVEC];
    int   n_vec  = 0;
    int   n_miss = 0;
    int   exp_cnt = 0;

    function automatic vec_t mk(input logic rd, input logic [3:0] wr, input logic [31:0] addr,
                                input logic [31:0] data, input logic [10:0] tag, input logic enf,
                                input logic macc, input logic acc, input logic fwd,
                                input logic viol, input logic blk);
        vec_t v;
        v.rd = rd; v.wr = wr; v.addr = addr; v.data = data; v.tag = tag;
        v.enf = enf; v.macc = macc;
        v.exp_acc = acc; v.exp_fwd = fwd; v.exp_viol = viol; v.exp_blk = blk;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic idle();
        core_rd_i = 1'b0; core_wr_i = 4'h0; core_addr_i = '0; core_data_wr_i = '0;
        core_req_tag_i = '0; mem_accept_i = 1'b1; mem_ack_i = 1'b0;
        mem_data_rd_i = '0; mem_error_i = 1'b0; mem_resp_tag_i = '0;
        stat_clr_i = 1'b0; log_pop_i = 1'b0; cfg_we_i = 1'b0;
    endtask

    task automatic drive_req(input logic rd, input logic [3:0] wr, input logic [31:0] addr,
                             input logic [31:0] data, input logic [10:0] tag);
        core_rd_i = rd; core_wr_i = wr; core_addr_i = addr;
        core_data_wr_i = data; core_req_tag_i = tag;
    endtask

    task automatic cfg_write(input logic [1:0] idx, input logic [31:0] base,
                             input logic [31:0] limit, input logic [2:0] perm);
        @(negedge clk_i);
        cfg_we_i = 1'b1; cfg_idx_i = idx; cfg_base_i = base;
        cfg_limit_i = limit; cfg_perm_i = perm;
        @(negedge clk_i);
        cfg_we_i = 1'b0;
    endtask

    task automatic pop_one();
        log_pop_i = 1'b1;
        @(negedge clk_i);
        log_pop_i = 1'b0;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        @(negedge clk_i);
        drive_req(v.rd, v.wr, v.addr, v.data, v.tag);
        enforce_i = v.enf; mem_accept_i = v.macc;
        #1;
        chk($sformatf("v%0d accept", idx), 64'(core_accept_o), 64'(v.exp_acc));
        chk($sformatf("v%0d mem_rd", idx), 64'(mem_rd_o), 64'(v.exp_fwd & v.rd));
        chk($sformatf("v%0d mem_wr", idx), 64'(mem_wr_o), 64'(v.exp_fwd ? v.wr : 4'h0));
        chk($sformatf("v%0d mem_addr", idx), 64'(mem_addr_o), 64'(v.exp_fwd ? v.addr : 32'h0));
        chk($sformatf("v%0d mem_data", idx), 64'(mem_data_wr_o), 64'(v.exp_fwd ? v.data : 32'h0));
        chk($sformatf("v%0d mem_tag", idx), 64'(mem_req_tag_o), 64'(v.exp_fwd ? v.tag : 11'h0));
        chk($sformatf("v%0d mem_cach", idx), 64'(mem_cacheable_o), 64'(v.exp_fwd));
        if (v.exp_viol) exp_cnt++;
        @(negedge clk_i);
        idle();
        #1;
        chk($sformatf("v%0d resp_ack", idx), 64'(core_ack_o), 64'(v.exp_blk));
        chk($sformatf("v%0d resp_err", idx), 64'(core_error_o), 64'(v.exp_blk));
        chk($sformatf("v%0d resp_tag", idx), 64'(core_resp_tag_o), 64'(v.exp_blk ? v.tag : 11'h0));
        chk($sformatf("v%0d log_valid", idx), 64'(log_valid_o), 64'(v.exp_viol));
        chk($sformatf("v%0d count", idx), 64'(viol_count_o), 64'(exp_cnt));
        if (v.exp_viol) begin
            chk($sformatf("v%0d log_addr", idx), 64'(log_addr_o), 64'(v.addr));
            chk($sformatf("v%0d log_data", idx), 64'(log_data_o), 64'((|v.wr) ? v.data : 32'h0));
            chk($sformatf("v%0d log_strb", idx), 64'(log_strb_o), 64'(v.wr));
            chk($sformatf("v%0d log_tag", idx), 64'(log_tag_o), 64'(v.tag));
            pop_one();
            #1;
            chk($sformatf("v%0d log_empty", idx), 64'(log_valid_o), 64'h0);
        end
    endtask

    initial begin
        //           rd wr    addr          data          tag     enf macc acc fwd viol blk
        vecs[0]  = mk(0, 4'hF, 32'h80000000, 32'hDEADAEEF, 11'h011, 1, 1,  1,  1,  0,  0);
        vecs[1]  = mk(1, 4'h0, 32'h80000004, 32'h00000000, 11'h012, 1, 1,  1,  1,  0,  0);
        vecs[2]  = mk(0, 4'hF, 32'h90000000, 32'hDEADAEEF, 11'h123, 1, 1,  1,  0,  1,  1);
        vecs[3]  = mk(1, 4'h0, 32'h90000000, 32'h55555555, 11'h124, 1, 0,  1,  0,  1,  1);
        vecs[4]  = mk(0, 4'hF, 32'h90000000, 32'hDEADAEEF, 11'h125, 0, 1,  1,  1,  1,  0);
        vecs[5]  = mk(1, 4'h0, 32'hA0000010, 32'h00000000, 11'h126, 1, 1,  1,  1,  0,  0);
        vecs[6]  = mk(0, 4'h3, 32'hA0000010, 32'h0000BEEF, 11'h127, 1, 1,  1,  0,  1,  1);
        vecs[7]  = mk(0, 4'h1, 32'h8FFFFFFF, 32'h00000011, 11'h128, 1, 1,  1,  1,  0,  0);
        vecs[8]  = mk(0, 4'h8, 32'h7FFFFFFF, 32'h00000022, 11'h129, 1, 1,  1,  0,  1,  1);
        vecs[9]  = mk(0, 4'hF, 32'hA0001000, 32'h00000033, 11'h12A, 0, 0,  0,  1,  0,  0);
        vecs[10] = mk(1, 4'h0, 32'h80000100, 32'h00000000, 11'h12B, 1, 0,  0,  1,  0,  0);
        vecs[11] = mk(0, 4'h0, 32'h00000000, 32'h00000000, 11'h000, 1, 1,  1,  0,  0,  0);
        // region0 read-only, region1 RW overlapping it at a higher index
        vecs[12] = mk(1, 4'h0, 32'h80000010, 32'h00000000, 11'h200, 1, 1,  1,  1,  0,  0);
        vecs[13] = mk(0, 4'hF, 32'h80000010, 32'hCAFEF00D, 11'h201, 1, 1,  1,  0,  1,  1);
        vecs[14] = mk(0, 4'hF, 32'h80000200, 32'h12121212, 11'h202, 0, 1,  1,  1,  1,  0);

        rst_ni = 1'b0;
        idle();
        core_cacheable_i = 1'b1;
        enforce_i = 1'b1;
        cfg_idx_i = '0; cfg_base_i = '0; cfg_limit_i = '0; cfg_perm_i = '0;
        #12;
        chk("rst accept", 64'(core_accept_o), 64'h1);
        chk("rst ack", 64'(core_ack_o), 64'h0);
        chk("rst mem_wr", 64'(mem_wr_o), 64'h0);
        chk("rst mem_addr", 64'(mem_addr_o), 64'h0);
        chk("rst log_valid", 64'(log_valid_o), 64'h0);
        chk("rst log_addr", 64'(log_addr_o), 64'h0);
        chk("rst count", 64'(viol_count_o), 64'h0);
        chk("rst overflow", 64'(log_overflow_o), 64'h0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        cfg_write(2'd0, 32'h80000000, 32'h8FFFFFFF, 3'b111);
        cfg_write(2'd1, 32'hA0000000, 32'hA0000FFF, 3'b101);
        for (int i = 0; i < c_PHASE2; i++) run_vec(i, vecs[i]);

        cfg_write(2'd0, 32'h80000000, 32'h8FFFFFFF, 3'b101);
        cfg_write(2'd1, 32'h80000000, 32'h800000FF, 3'b111);
        for (int i = c_PHASE2; i < c_NVEC; i++) run_vec(i, vecs[i]);

        // ---- blocked error collides with a fabric response ----
        @(negedge clk_i);
        enforce_i = 1'b1;
        drive_req(1'b0, 4'hF, 32'h90000000, 32'h0BADF00D, 11'h055);
        #1;
        chk("col accept0", 64'(core_accept_o), 64'h1);
        chk("col mem_wr0", 64'(mem_wr_o), 64'h0);
        exp_cnt++;
        @(negedge clk_i);
        drive_req(1'b1, 4'h0, 32'h80000010, 32'h0, 11'h056);
        mem_ack_i = 1'b1; mem_data_rd_i = 32'h12345678; mem_resp_tag_i = 11'h077;
        #1;
        chk("col ack1", 64'(core_ack_o), 64'h1);
        chk("col err1", 64'(core_error_o), 64'h0);
        chk("col data1", 64'(core_data_rd_o), 64'h12345678);
        chk("col tag1", 64'(core_resp_tag_o), 64'h077);
        chk("col accept1", 64'(core_accept_o), 64'h0);
        chk("col mem_rd1", 64'(mem_rd_o), 64'h0);
        @(negedge clk_i);
        mem_ack_i = 1'b0; mem_data_rd_i = '0; mem_resp_tag_i = '0;
        #1;
        chk("col ack2", 64'(core_ack_o), 64'h1);
        chk("col err2", 64'(core_error_o), 64'h1);
        chk("col data2", 64'(core_data_rd_o), 64'h0);
        chk("col tag2", 64'(core_resp_tag_o), 64'h055);
        chk("col accept2", 64'(core_accept_o), 64'h0);
        @(negedge clk_i);
        #1;
        chk("col ack3", 64'(core_ack_o), 64'h0);
        chk("col accept3", 64'(core_accept_o), 64'h1);
        chk("col mem_rd3", 64'(mem_rd_o), 64'h1);
        @(negedge clk_i);
        idle();
        #1;
        chk("col log_tag", 64'(log_tag_o), 64'h055);
        chk("col count", 64'(viol_count_o), 64'(exp_cnt));
        pop_one();

        // ---- overflow: LOG_DEPTH+1 violations without popping ----
        enforce_i = 1'b0;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk_i);
            drive_req(1'b0, 4'hF, 32'h90000000 + 32'(4 * k), 32'(k), 11'(k));
            if (k == 8) begin
                #1;
                chk("ovf before", 64'(log_overflow_o), 64'h0);
            end
            exp_cnt++;
        end
        @(negedge clk_i);
        idle();
        #1;
        chk("ovf set", 64'(log_overflow_o), 64'h1);
        chk("ovf count", 64'(viol_count_o), 64'(exp_cnt));
        for (int k = 0; k < 8; k++) begin
            #1;
            chk($sformatf("ovf head%0d", k), 64'(log_addr_o), 64'(32'h90000000 + 32'(4 * k)));
            pop_one();
        end
        #1;
        chk("ovf drained", 64'(log_valid_o), 64'h0);

        @(negedge clk_i);
        stat_clr_i = 1'b1;
        @(negedge clk_i);
        stat_clr_i = 1'b0;
        exp_cnt = 0;
        #1;
        chk("clr count", 64'(viol_count_o), 64'h0);
        chk("clr overflow", 64'(log_overflow_o), 64'h0);

        for (int k = 0; k < 8; k++) begin
            @(negedge clk_i);
            drive_req(1'b0, 4'hF, 32'h90001000 + 32'(4 * k), 32'(k), 11'(k));
            exp_cnt++;
        end
        @(negedge clk_i);
        drive_req(1'b0, 4'hF, 32'h90001020, 32'h8, 11'h8);
        log_pop_i = 1'b1;
        exp_cnt++;
        @(negedge clk_i);
        idle();
        #1;
        chk("pp overflow", 64'(log_overflow_o), 64'h0);
        chk("pp head", 64'(log_addr_o), 64'h90001004);
        chk("pp count", 64'(viol_count_o), 64'(exp_cnt));

        @(negedge clk_i);
        drive_req(1'b0, 4'hF, 32'h90001024, 32'h9, 11'h9);
        stat_clr_i = 1'b1;
        exp_cnt = 1;
        @(negedge clk_i);
        idle();
        #1;
        chk("clrv count", 64'(viol_count_o), 64'h1);
        chk("clrv overflow", 64'(log_overflow_o), 64'h1);
        for (int k = 1; k < 9; k++) begin
            #1;
            chk($sformatf("pp head%0d", k), 64'(log_addr_o), 64'(32'h90001000 + 32'(4 * k)));
            pop_one();
        end
        #1;
        chk("pp drained", 64'(log_valid_o), 64'h0);

        // ---- config write does not affect the same-cycle request ----
        @(negedge clk_i);
        enforce_i = 1'b1;
        cfg_we_i = 1'b1; cfg_idx_i = 2'd2; cfg_base_i = 32'h90000000;
        cfg_limit_i = 32'h9FFFFFFF; cfg_perm_i = 3'b111;
        drive_req(1'b0, 4'hF, 32'h90000000, 32'hA5A5A5A5, 11'h3AA);
        #1;
        chk("cfg accept0", 64'(core_accept_o), 64'h1);
        chk("cfg mem_wr0", 64'(mem_wr_o), 64'h0);
        exp_cnt++;
        @(negedge clk_i);
        cfg_we_i = 1'b0;
        core_req_tag_i = 11'h3AB;
        #1;
        chk("cfg accept1", 64'(core_accept_o), 64'h0);
        chk("cfg err1", 64'(core_error_o), 64'h1);
        chk("cfg tag1", 64'(core_resp_tag_o), 64'h3AA);
        @(negedge clk_i);
        #1;
        chk("cfg accept2", 64'(core_accept_o), 64'h1);
        chk("cfg mem_wr2", 64'(mem_wr_o), 64'hF);
        @(negedge clk_i);
        idle();
        #1;
        chk("cfg count", 64'(viol_count_o), 64'(exp_cnt));
        chk("cfg log_tag", 64'(log_tag_o), 64'h3AA);
        pop_one();

        // ---- reset while an error response is pending ----
        @(negedge clk_i);
        drive_req(1'b0, 4'hF, 32'h70000000, 32'h1, 11'h444);
        @(negedge clk_i);
        idle();
        rst_ni = 1'b0;
        #1;
        chk("mrst ack", 64'(core_ack_o), 64'h0);
        chk("mrst log_valid", 64'(log_valid_o), 64'h0);
        chk("mrst count", 64'(viol_count_o), 64'h0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
        chk("mrst ack2", 64'(core_ack_o), 64'h0);
        @(negedge clk_i);
        drive_req(1'b0, 4'hF, 32'h80000000, 32'h2, 11'h445);
        #1;
        chk("mrst accept", 64'(core_accept_o), 64'h1);
        chk("mrst mem_wr", 64'(mem_wr_o), 64'h0);
        @(negedge clk_i);
        idle();
        #1;
        chk("mrst err", 64'(core_error_o), 64'h1);
        chk("mrst count2", 64'(viol_count_o), 64'h1);
        @(negedge clk_i);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no end of test, expected finish before 200000");
        $fatal(1);
    end

endmodule : tb_dmem_access_guard
`default_nettype wire

// File: doc/dmem_access_guard.md
# dmem_access_guard

Parametrised data-memory access guard between the `riscv_core` data port and the memory/cache fabric. It checks every core load and store against NUM_REGIONS programmable address windows. Denied accesses are either blocked with an error response or passed through, depending on mode. Each violation is logged into a FIFO and counted, replacing the testbench-only store monitoring with synthesisable enforcement.

## Interface
Parameters:
- NUM_REGIONS, 4, number of address windows (1–16)
- LOG_DEPTH, 8, violation FIFO depth; power of two, at least 2
- CNT_W, 16, width of the violation counter
- DEFAULT_ALLOW, 0, decision when no enabled region matches (1 = allow)

Ports (all address/data buses 32 bits, tag buses 11 bits):
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous, active-low reset
- core_addr_i / core_data_wr_i  in  32  core request address / store data
- core_rd_i  in  1  load request
- core_wr_i  in  4  store byte strobes
- core_cacheable_i  in  1  cacheable attribute
- core_req_tag_i  in  11  request tag
- core_accept_o  out  1  request accepted this cycle
- core_data_rd_o  out  32  load data
- core_ack_o / core_error_o  out  1  response valid / response error
- core_resp_tag_o  out  11  response tag
- mem_addr_o, mem_data_wr_o, mem_rd_o, mem_wr_o, mem_cacheable_o, mem_req_tag_o  out  widths as core side  downstream request
- mem_accept_i, mem_data_rd_i, mem_ack_i, mem_error_i, mem_resp_tag_i  in  widths as core side  downstream accept/response
- enforce_i  in  1  1 = block denied accesses; 0 = log only
- cfg_we_i  in  1  region write strobe
- cfg_idx_i  in  $clog2(NUM_REGIONS)  region index
- cfg_base_i / cfg_limit_i  in  32  inclusive window bounds
- cfg_perm_i  in  3  {enable, write, read}
- log_valid_o  out  1  FIFO non-empty
- log_pop_i  in  1  pop head entry
- log_addr_o / log_data_o  out  32  head entry address / store data (0 for loads)
- log_strb_o  out  4  head entry strobes (0 = load)
- log_tag_o  out  11  head entry tag
- log_overflow_o  out  1  sticky: an entry was dropped
- viol_count_o  out  CNT_W  saturating violation count
- stat_clr_i  in  1  clears viol_count_o and log_overflow_o

## Operation
- A request is `core_rd_i | |core_wr_i`. Store if any strobe is set; load otherwise.
- Region match: enabled and `base <= addr <= limit`, unsigned. The lowest-index matching region decides: reads need the R bit, writes need the W bit. With no match, DEFAULT_ALLOW decides.
- Allowed request: passed combinationally to mem_*. `core_accept_o = mem_accept_i & ~err_pend`.
- Denied request, enforce_i=1:
  - mem_rd_o and mem_wr_o stay 0.
  - `core_accept_o = ~err_pend`.
  - On accept, set err_pend and capture the tag.
- Denied request, enforce_i=0: treated as allowed on the bus; still logged and counted.
- While err_pend=1: no request is forwarded, and core_accept_o=0.
- Response mux:
  - mem_ack_i has priority and is passed through unchanged.
  - Otherwise, if err_pend: core_ack_o=1, core_error_o=1, core_data_rd_o=0, core_resp_tag_o=captured tag; err_pend clears.
- Violation event = request & denied & core_accept_o.
  - Push {addr, store data or 0, strobes, tag} to the FIFO.
  - viol_count_o increments, saturating at all-ones.
- FIFO full on a push: entry dropped and log_overflow_o set, unless log_pop_i is asserted in the same cycle; then the push succeeds.
- Pop on an empty FIFO is ignored.
- stat_clr_i coinciding with a violation: the counter becomes 1 and the overflow flag follows the same-cycle push result.
- Config writes take effect the next cycle; a request in the write cycle uses the old configuration.

## Timing
- Reset values:
  - All regions disabled, base=limit=0.
  - err_pend=0, FIFO empty.
  - All core_*/mem_* outputs 0, except core_accept_o, which follows its equations.
  - log_* outputs 0, viol_count_o=0, log_overflow_o=0.
- Allowed path: 0-cycle request latency; response latency is whatever the memory provides.
- Blocked path: error response no earlier than the cycle after accept. Each same-cycle mem_ack_i delays it one further cycle.
- Log: entry visible on log_valid_o the cycle after the violation. FIFO head outputs are registered.
- Reset asserted mid-transaction: err_pend, FIFO and regions cleared immediately; the pending error response is lost.

## Structure
- Package `dmem_guard_pkg`:
  - region_t struct {base, limit, en, w, r}
  - log_entry_t struct
  - PERM_R/PERM_W/PERM_EN bit indices
- Sub-module `dmem_guard_log_fifo`: synchronous FIFO of log_entry_t, parametrised by LOG_DEPTH, with full/empty flags and pointer wrap. Instantiated once.

## Test plan
- Region0 = 0x80000000–0x8FFFFFFF, RW, enforce=1. SW 0xDEADAEEF to 0x80000000 -> mem_wr_o=0xF, mem_addr_o=0x80000000, same cycle; no log entry.
- Same setup, SW 0xDEADAEEF to 0x90000000 -> mem_wr_o stays 0; next cycle core_ack_o=1, core_error_o=1 with the request tag; log entry {0x90000000, 0xDEADAEEF, 0xF}; viol_count_o=1.
- enforce=0, same store -> forwarded to mem; logged; count increments.
- Region0 read-only, LW from 0x80000010 allowed; SW to the same address denied. Overlapping region1 RW at index 1 does not override region0.
- Blocked error pending while mem_ack_i arrives in the same cycle -> mem response first, error response next cycle; core_accept_o=0 throughout.
- LOG_DEPTH+1 violations without popping -> log_overflow_o=1 and FIFO holds the first LOG_DEPTH entries. Push with simultaneous pop when full -> no overflow. stat_clr_i clears the count and the flag.
